// File: rtl/mc_alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op codes, FSM states, op classifier.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ops that are handed to the bit-serial multiply/divide engine
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mc_alu_iter.sv
// Bit-serial multiply (radix-2 shift-add) and restoring divide, one bit per cycle.
// The first bit is processed on the start edge itself, so after CYCLES edges
// (start included) 'done' is raised and the result is stable in the registers.
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(CYCLES + 1);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] m_r;   // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] hi;    // upper product half / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier shifting out / quotient shifting in

  logic [3:0]       op_c;
  logic             mul_c;
  logic [WIDTH-1:0] m_c, hi_c, lo_c, hi_n, lo_n;
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] diff;

  // On start the step works directly on the fresh operands
  assign op_c  = start ? op : op_r;
  assign mul_c = (op_c == OP_MUL) || (op_c == OP_MULHU);
  assign m_c   = start ? (mul_c ? a : b) : m_r;
  assign hi_c  = start ? '0 : hi;
  assign lo_c  = start ? (mul_c ? b : a) : lo;

  // One iteration of either algorithm
  always_comb begin
    sum  = {1'b0, hi_c} + (lo_c[0] ? {1'b0, m_c} : '0);
    sh   = {hi_c, lo_c[WIDTH-1]};
    // partial remainder is always below 2^WIDTH when the subtract succeeds
    diff = sh[WIDTH-1:0] - m_c;
    hi_n = hi_c;
    lo_n = lo_c;
    if (mul_c) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_c[WIDTH-1:1]};
    end else if (sh >= {1'b0, m_c}) begin
      hi_n = diff;
      lo_n = {lo_c[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = sh[WIDTH-1:0];
      lo_n = {lo_c[WIDTH-2:0], 1'b0};
    end
  end

  assign done   = run && (cnt == CW'(CYCLES));
  assign result = ((op_r == OP_MUL) || (op_r == OP_DIVU)) ? lo : hi;

  // Iteration state: load+first step on start, step until the count is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      op_r <= '0;
      m_r  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= CW'(1);
      op_r <= op;
      m_r  <= m_c;
      hi   <= hi_n;
      lo   <= lo_n;
    end else if (run) begin
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        hi  <= hi_n;
        lo  <= lo_n;
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus bit-serial mul/div,
// valid/ready handshake on both sides, result held until consumed.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ITER_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_e state, state_n;

  logic             accept, iter_op, iter_done;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH:0]   add_s, sub_s;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] c_res;
  logic             c_carry, c_ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign iter_op   = is_iter(op);

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign shamt = b[SW-1:0];

  mc_alu_iter #(.WIDTH(WIDTH), .CYCLES(ITER_CYCLES)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_op),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_res)
  );

  // Single-cycle datapath; unassigned codes fall through to all-zero
  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        c_res   = add_s[M:0];
        c_carry = add_s[WIDTH];
        c_ovf   = (a[M] == b[M]) && (add_s[M] != a[M]);
      end
      OP_SUB: begin
        c_res   = sub_s[M:0];
        c_carry = sub_s[WIDTH];
        c_ovf   = (a[M] != b[M]) && (sub_s[M] != a[M]);
      end
      OP_AND:  c_res = a & b;
      OP_OR:   c_res = a | b;
      OP_XOR:  c_res = a ^ b;
      OP_SLT: begin
        c_res   = {{M{1'b0}}, ($signed(a) < $signed(b))};
        c_carry = sub_s[WIDTH];
      end
      OP_SLTU: begin
        c_res   = {{M{1'b0}}, (a < b)};
        c_carry = sub_s[WIDTH];
      end
      OP_SLL:  c_res = a << shamt;
      OP_SRL:  c_res = a >> shamt;
      OP_SRA:  c_res = $unsigned($signed(a) >>> shamt);
      default: c_res = '0;
    endcase
  end

  // Result/flag register: loaded on single-cycle accept or iterative completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (accept && !iter_op) begin
      result   <= c_res;
      carry    <= c_carry;
      overflow <= c_ovf;
      zero     <= (c_res == '0);
      negative <= c_res[M];
    end else if ((state == BUSY) && iter_done) begin
      result   <= iter_res;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= (iter_res == '0);
      negative <= iter_res[M];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // FSM next state; the handshake cycle never accepts a new request
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = iter_op ? BUSY : DONE;
      BUSY:    if (iter_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu: WIDTH=32 and WIDTH=8 instances sharing stimulus,
// table of hand-computed vectors plus back-pressure and mid-op reset sequences.
module tb_mc_alu;
  import mc_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;   // 0: WIDTH=32 instance, 1: WIDTH=8 instance
  logic        iv = 1'b0, ordy = 1'b0;
  logic [3:0]  opi = '0;
  logic [63:0] ai = '0, bi = '0;

  logic        iv32, ir32, ov32, c32, v32, z32, n32, bz32;
  logic [31:0] res32;
  logic        iv8, ir8, ov8, c8, v8, z8, n8, bz8;
  logic [7:0]  res8;

  assign iv32 = iv & ~sel;
  assign iv8  = iv & sel;

  mc_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(opi),
    .a(ai[31:0]), .b(bi[31:0]), .out_valid(ov32), .out_ready(ordy),
    .result(res32), .carry(c32), .overflow(v32), .zero(z32),
    .negative(n32), .busy(bz32)
  );

  mc_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(opi),
    .a(ai[7:0]), .b(bi[7:0]), .out_valid(ov8), .out_ready(ordy),
    .result(res8), .carry(c8), .overflow(v8), .zero(z8),
    .negative(n8), .busy(bz8)
  );

  logic        ir, ov, bz;
  logic [63:0] res;
  logic [3:0]  flg;   // {carry, overflow, zero, negative}
  assign ir  = sel ? ir8 : ir32;
  assign ov  = sel ? ov8 : ov32;
  assign bz  = sel ? bz8 : bz32;
  assign res = sel ? {56'd0, res8} : {32'd0, res32};
  assign flg = sel ? {c8, v8, z8, n8} : {c32, v32, z32, n32};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        w8;
    logic [3:0]  op;
    logic [63:0] a, b, res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input logic w8, input logic [3:0] op,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] r, input logic [3:0] f, input int lat);
    vec_t v;
    v.name = nm; v.w8 = w8; v.op = op; v.a = a; v.b = b;
    v.res = r; v.flg = f; v.lat = lat;
    return v;
  endfunction

  // Issue one request, measure latency, check result/flags, then consume it
  task automatic run_op(input vec_t v);
    int   n;
    logic stall_ok;
    sel = v.w8;
    @(negedge clk);
    chk({v.name, " in_ready"}, 64'(ir), 64'd1);
    iv = 1'b1; opi = v.op; ai = v.a; bi = v.b;
    @(posedge clk);
    #1 iv = 1'b0;
    n = 1;
    stall_ok = 1'b1;
    while (!ov && n < 200) begin
      if (ir) stall_ok = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    if (ir) stall_ok = 1'b0;
    chk({v.name, " latency"}, 64'(n), 64'(v.lat));
    chk({v.name, " in_ready_low"}, 64'(stall_ok), 64'd1);
    chk({v.name, " result"}, res, v.res);
    chk({v.name, " flags"}, 64'(flg), 64'(v.flg));
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk({v.name, " out_valid_drop"}, 64'(ov), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    // flags column is {carry, overflow, zero, negative}
    vt.push_back(mk("add_ovf32",  0, OP_ADD,   64'h7FFFFFFF, 64'h1,  64'h80000000, 4'b0101, 1));
    vt.push_back(mk("sub_eq32",   0, OP_SUB,   64'h5, 64'h5,                64'h0,        4'b1010, 1));
    vt.push_back(mk("slt32",      0, OP_SLT,   64'hFFFFFFFF, 64'h1,         64'h1,        4'b1000, 1));
    vt.push_back(mk("sltu32",     0, OP_SLTU,  64'hFFFFFFFF, 64'h1,         64'h0,        4'b1010, 1));
    vt.push_back(mk("slt_pos32",  0, OP_SLT,   64'h1, 64'hFFFFFFFF,         64'h0,        4'b0010, 1));
    vt.push_back(mk("add_wrap32", 0, OP_ADD,   64'hFFFFFFFF, 64'h1,         64'h0,        4'b1010, 1));
    vt.push_back(mk("sub_brw32",  0, OP_SUB,   64'h0, 64'h1,                64'hFFFFFFFF, 4'b0001, 1));
    vt.push_back(mk("sub_ovf32",  0, OP_SUB,   64'h80000000, 64'h1,         64'h7FFFFFFF, 4'b1100, 1));
    vt.push_back(mk("and32",      0, OP_AND,   64'hF0F0F0F0, 64'h0FF00FF0,  64'h00F000F0, 4'b0000, 1));
    vt.push_back(mk("or32",       0, OP_OR,    64'h12340000, 64'h00005678,  64'h12345678, 4'b0000, 1));
    vt.push_back(mk("xor32",      0, OP_XOR,   64'hA5A5A5A5, 64'hFFFFFFFF,  64'h5A5A5A5A, 4'b0000, 1));
    vt.push_back(mk("sll32",      0, OP_SLL,   64'h1, 64'h21,               64'h2,        4'b0000, 1));
    vt.push_back(mk("srl32",      0, OP_SRL,   64'h80000000, 64'h1F,        64'h1,        4'b0000, 1));
    vt.push_back(mk("sra32",      0, OP_SRA,   64'h80000000, 64'h24,        64'hF8000000, 4'b0001, 1));
    vt.push_back(mk("undef32",    0, 4'd14,    64'h1234, 64'h5678,          64'h0,        4'b0010, 1));
    vt.push_back(mk("mul32",      0, OP_MUL,   64'hFFFFFFFF, 64'hFFFFFFFF,  64'h1,        4'b0000, 33));
    vt.push_back(mk("mulhu32",    0, OP_MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF,  64'hFFFFFFFE, 4'b0001, 33));
    vt.push_back(mk("divu32",     0, OP_DIVU,  64'd100, 64'd7,              64'd14,       4'b0000, 33));
    vt.push_back(mk("remu32",     0, OP_REMU,  64'd100, 64'd7,              64'd2,        4'b0000, 33));
    vt.push_back(mk("divu0_32",   0, OP_DIVU,  64'd9, 64'd0,                64'hFFFFFFFF, 4'b0001, 33));
    vt.push_back(mk("remu0_32",   0, OP_REMU,  64'd9, 64'd0,                64'd9,        4'b0000, 33));
    vt.push_back(mk("add_ovf8",   1, OP_ADD,   64'h7F, 64'h1,               64'h80,       4'b0101, 1));
    vt.push_back(mk("sub_eq8",    1, OP_SUB,   64'h5, 64'h5,                64'h0,        4'b1010, 1));
    vt.push_back(mk("slt8",       1, OP_SLT,   64'hFF, 64'h1,               64'h1,        4'b1000, 1));
    vt.push_back(mk("sltu8",      1, OP_SLTU,  64'hFF, 64'h1,               64'h0,        4'b1010, 1));
    vt.push_back(mk("sra8",       1, OP_SRA,   64'h80, 64'h0B,              64'hF0,       4'b0001, 1));
    vt.push_back(mk("mul8",       1, OP_MUL,   64'hFF, 64'hFF,              64'h01,       4'b0000, 9));
    vt.push_back(mk("mulhu8",     1, OP_MULHU, 64'hFF, 64'hFF,              64'hFE,       4'b0001, 9));
    vt.push_back(mk("mul8b",      1, OP_MUL,   64'h0D, 64'h0B,              64'h8F,       4'b0001, 9));
    vt.push_back(mk("mulhu8b",    1, OP_MULHU, 64'h0D, 64'h0B,              64'h00,       4'b0010, 9));
    vt.push_back(mk("divu8",      1, OP_DIVU,  64'd100, 64'd7,              64'd14,       4'b0000, 9));
    vt.push_back(mk("remu8",      1, OP_REMU,  64'd100, 64'd7,              64'd2,        4'b0000, 9));
    vt.push_back(mk("divu0_8",    1, OP_DIVU,  64'd9, 64'd0,                64'hFF,       4'b0001, 9));
    vt.push_back(mk("remu0_8",    1, OP_REMU,  64'd9, 64'd0,                64'd9,        4'b0000, 9));

    // Reset state of both instances
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst out_valid", 64'(ov), 64'd0);
      chk("rst busy", 64'(bz), 64'd0);
      chk("rst in_ready", 64'(ir), 64'd1);
      chk("rst result", res, 64'd0);
      chk("rst flags", 64'(flg), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_op(vt[i]);

    // Back-pressure: hold result 5 cycles while a new request waits on in_valid
    sel = 1'b0;
    @(negedge clk);
    iv = 1'b1; opi = OP_ADD; ai = 64'd10; bi = 64'd20;
    @(posedge clk);
    #1 ai = 64'd100; bi = 64'd200;
    chk("bp out_valid", 64'(ov), 64'd1);
    chk("bp result", res, 64'd30);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp hold result", res, 64'd30);
      chk("bp hold flags", 64'(flg), 64'd0);
      chk("bp hold in_ready", 64'(ir), 64'd0);
      chk("bp hold out_valid", 64'(ov), 64'd1);
    end
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk("bp handshake in_ready", 64'(ir), 64'd1);
    chk("bp handshake out_valid", 64'(ov), 64'd0);
    @(posedge clk);
    #1 iv = 1'b0;
    chk("bp second out_valid", 64'(ov), 64'd1);
    chk("bp second result", res, 64'd300);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;

    // Reset 10 cycles into a divide: the divide must never complete
    @(negedge clk);
    iv = 1'b1; opi = OP_DIVU; ai = 64'd100; bi = 64'd7;
    @(posedge clk);
    #1 iv = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort out_valid", 64'(ov), 64'd0);
    chk("abort busy", 64'(bz), 64'd0);
    chk("abort result", res, 64'd0);
    chk("abort flags", 64'(flg), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort in_ready", 64'(ir), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ov) seen = 1'b1;
    end
    chk("abort no result", 64'(seen), 64'd0);
    run_op(mk("add_after_rst", 0, OP_ADD, 64'd2, 64'd3, 64'd5, 4'b0000, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have parameter ITER_CYCLES, default WIDTH, number of cycles for MUL/MULHU/DIVU/REMU (fixed at WIDTH in this generation; exported for benches).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  4  operation code, from package encoding.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have ports carry, overflow, zero, negative  output  1 each  status flags.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-015 Request SHALL be accepted on an edge where in_valid && in_ready; a, b, op captured at that edge.
REQ-016 Single-cycle ops ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA SHALL go IDLE->DONE; out_valid high the cycle after acceptance.
REQ-017 Iterative ops MUL (low WIDTH bits), MULHU (high WIDTH bits, unsigned), DIVU, REMU SHALL go IDLE->BUSY; out_valid rises exactly ITER_CYCLES+1 cycles after acceptance.
REQ-018 MUL/MULHU SHALL use radix-2 shift-add, one bit per cycle; DIVU/REMU SHALL use restoring division, one bit per cycle.
REQ-019 DIVU by zero SHALL give all-ones; REMU by zero SHALL give a; same latency as a normal divide.
REQ-020 Shift amount SHALL be b[$clog2(WIDTH)-1:0]; upper bits of b ignored.
REQ-021 SLT signed, SLTU unsigned; result zero-extended 0 or 1.
REQ-022 carry SHALL be carry-out of a+b (ADD) or a+~b+1 (SUB, SLT, SLTU); 0 otherwise.
REQ-023 overflow SHALL be two's-complement overflow for ADD/SUB; 0 otherwise.
REQ-024 zero = (result == 0); negative = result[WIDTH-1]; valid for all ops.
REQ-025 Unassigned op codes SHALL complete single-cycle with result 0, carry 0, overflow 0, zero 1.
REQ-026 In DONE, result and flags SHALL hold stable while out_ready is low.
REQ-027 DONE->IDLE on out_valid && out_ready; no new request accepted in that same cycle.
REQ-028 in_valid, op, a, b changes during BUSY/DONE SHALL be ignored.

Reset
REQ-029 While rst low: state IDLE, out_valid 0, busy 0, result 0, all flags 0, iteration counter 0.
REQ-030 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result ever presented; in_ready high first cycle after release.

Structure
REQ-031 Package mc_alu_pkg SHALL hold op encodings (ADD=0,SUB=1,AND=2,OR=3,XOR=4,SLT=5,SLTU=6,SLL=7,SRL=8,SRA=9,MUL=10,MULHU=11,DIVU=12,REMU=13) and FSM state enum.
REQ-032 Iterative multiply/divide SHALL live in one sub-module mc_alu_iter (start, op, a, b in; done, result out); combinational ops stay in mc_alu.

Verification
REQ-033 WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> next cycle result 0x80000000, overflow 1, negative 1, carry 0, zero 0.
REQ-034 SUB 5-5 -> result 0, zero 1, carry 1, overflow 0; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-035 MUL and MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE, out_valid exactly 33 cycles after acceptance, in_ready 0 throughout.
REQ-036 DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9.
REQ-037 out_ready low 5 cycles after out_valid -> result/flags unchanged, in_ready 0; request held on in_valid accepted only the cycle after handshake.
REQ-038 rst low 10 cycles into DIVU -> out_valid never rises for it; after release ADD 2+3 -> 5; repeat REQ-033..036 with WIDTH=8 (latency 9).
